// File: rtl/event_arbiter_pkg.sv
// Shared helpers for the event arbiter: index-width derivation, counter
// capacity and the round-robin successor function.
package event_arbiter_pkg;

    localparam int NUM_CH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT  = 4;
    localparam int CNT_MAX_DEFAULT = (1 << CNT_W_DEFAULT) - 1;

    // Ceil-log2 that never returns less than one bit, so a channel index
    // always has a real wire even for degenerate channel counts.
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/event_edge_sync.sv
// One event channel: two-flop synchronizer plus a history flop, producing a
// single-cycle pulse per rising edge. The chain freezes while enable is low.
module event_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else if (enable) begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Stays high across disabled cycles, so an edge seen just before a
    // freeze is still counted once enable returns.
    assign pulse = s2 & ~s3;

endmodule

// File: rtl/event_arbiter.sv
// Multi-channel event collector: per-channel saturating pending counters
// drained one event at a time, round-robin, into a valid/ready output.
module event_arbiter
    import event_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4,
    localparam int IDX_W = idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] evt_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_ch,
    output logic [NUM_CH-1:0] overflow,
    input  logic              ovf_clear,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] deq;
    logic [NUM_CH-1:0] nonzero;
    logic [NUM_CH-1:0] ovf_set;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  pick;
    logic              found;
    logic              free;
    logic              grant;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        event_edge_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .in     (evt_in[g]),
            .pulse  (pulse[g])
        );
    end

    // Front end -> counters
    assign inc  = pulse & {NUM_CH{enable}};
    assign free = !out_valid || out_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonzero[i] = (cnt[i] != '0);
        end
    end

    // First nonzero channel strictly after the previous winner.
    always_comb begin : rr_search
        int               cand;
        logic [IDX_W-1:0] cidx;
        found = 1'b0;
        pick  = last;
        cand  = int'(last);
        cidx  = last;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = rr_next(cand, NUM_CH);
            cidx = IDX_W'(cand);
            if (!found && nonzero[cidx]) begin
                found = 1'b1;
                pick  = cidx;
            end
        end
    end

    assign grant = free && enable && found;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            deq[i]     = grant && (pick == IDX_W'(i));
            ovf_set[i] = inc[i] && !deq[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (inc[i] && !deq[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end else if (deq[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // A set landing together with a clear must survive, hence OR after clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= '0;
        end else begin
            overflow <= (ovf_clear ? '0 : overflow) | ovf_set;
        end
    end

    // Counters -> output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            last      <= IDX_W'(NUM_CH - 1);
        end else if (free) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_ch    <= pick;
                last      <= pick;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = out_valid || (|nonzero);

endmodule

// File: tb/tb_event_arbiter.sv
// Randomized and directed bench for event_arbiter with a queue-based
// scoreboard fed by an event-level reference model.
module tb_event_arbiter;
    import event_arbiter_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 2;
    localparam int IDX_W  = idx_width(NUM_CH);
    localparam int CAP    = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [NUM_CH-1:0] evt_in;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_ch;
    logic [NUM_CH-1:0] overflow;
    logic              ovf_clear;
    logic              busy;

    event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .evt_in    (evt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: pending events per channel, the grant held by
    // the consumer side, and the enabled-cycle time at which each detected
    // edge becomes countable.
    int                mpend [NUM_CH];
    int                arr_q [NUM_CH][$];
    int                mlast  = NUM_CH - 1;
    bit                mvalid = 1'b0;
    bit [NUM_CH-1:0]   movf   = '0;
    bit [NUM_CH-1:0]   mprev  = '0;
    int                ecount = 0;
    int                exp_q[$];
    int                xfer_log[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        int              pick;
        int              nv;
        int              arrive;
        int              c;
        bit [NUM_CH-1:0] setb;
        for (int i = 0; i < NUM_CH; i++) mpend[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    mpend[i] = 0;
                    arr_q[i].delete();
                end
                mprev  = '0;
                mvalid = 1'b0;
                mlast  = NUM_CH - 1;
                movf   = '0;
                exp_q.delete();
            end else begin
                pick = -1;
                if ((!mvalid || out_ready) && enable) begin
                    for (int k = 1; k <= NUM_CH; k++) begin
                        c = (mlast + k) % NUM_CH;
                        if (pick < 0 && mpend[c] > 0) pick = c;
                    end
                end
                if (!mvalid || out_ready) begin
                    if (pick >= 0) begin
                        mvalid = 1'b1;
                        mlast  = pick;
                        exp_q.push_back(pick);
                    end else begin
                        mvalid = 1'b0;
                    end
                end
                if (enable) ecount++;
                setb = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    arrive = 0;
                    if (enable) begin
                        if (arr_q[i].size() > 0 && arr_q[i][0] == ecount) begin
                            void'(arr_q[i].pop_front());
                            arrive = 1;
                        end
                        if (evt_in[i] && !mprev[i]) arr_q[i].push_back(ecount + 2);
                        mprev[i] = evt_in[i];
                    end
                    nv = mpend[i] - ((pick == i) ? 1 : 0) + arrive;
                    if (nv > CAP) begin
                        nv      = CAP;
                        setb[i] = 1'b1;
                    end
                    mpend[i] = nv;
                end
                movf = (ovf_clear ? '0 : movf) | setb;
            end
        end
    end

    initial begin : monitor
        bit mbusy;
        int e;
        forever begin
            @(negedge clk);
            mbusy = mvalid;
            for (int i = 0; i < NUM_CH; i++) if (mpend[i] != 0) mbusy = 1'b1;
            check("out_valid", out_valid, mvalid);
            check("overflow", overflow, movf);
            check("busy", busy, mbusy);
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_ch actual %0d expected none (no grant predicted) at %0t", out_ch, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ch", out_ch, e);
                end
                xfer_log.push_back(int'(out_ch));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ch(input logic [NUM_CH-1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            evt_in = evt_in | mask;
            tick(2);
            evt_in = evt_in & ~mask;
            tick(2);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        tick(4);
        for (int i = 0; i < budget && !done; i++) begin
            if (!busy) done = 1'b1;
            else tick(1);
        end
        check("drain_within_budget", done, 1);
    endtask

    initial begin : stimulus
        int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
        int bp_exp[4] = '{1, 2, 1, 2};
        int en_exp[3] = '{3, 0, 2};
        int hold[NUM_CH];
        int vcount;
        int n1;

        rst = 1'b1; enable = 1'b1; evt_in = '0; out_ready = 1'b0; ovf_clear = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_ch", out_ch, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);

        // single held event: grant exactly three edges after first capture
        out_ready = 1'b1;
        evt_in[2] = 1'b1;
        tick(3);
        check("latency_before_e3", out_valid, 0);
        tick(1);
        check("latency_e3_valid", out_valid, 1);
        check("latency_e3_ch", out_ch, 2);
        tick(1);
        check("single_valid_drop", out_valid, 0);
        tick(4);
        check("held_level_one_event", busy, 0);
        evt_in[2] = 1'b0;
        tick(2);

        // round robin, continuous once released
        rst = 1'b1; tick(1); rst = 1'b0;
        out_ready = 1'b0;
        pulse_ch(4'b1011, 2);
        tick(2);
        xfer_log.delete();
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) vcount++;
            tick(1);
        end
        check("rr_continuous_cycles", vcount, 6);
        check("rr_idle_after", out_valid, 0);
        check("rr_count", xfer_log.size(), 6);
        if (xfer_log.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), xfer_log[i], rr_exp[i]);

        // backpressure
        out_ready = 1'b0;
        pulse_ch(4'b0110, 2);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ch", out_ch, 1);
            tick(1);
        end
        xfer_log.delete();
        out_ready = 1'b1;
        wait_idle(20);
        check("bp_count", xfer_log.size(), 4);
        if (xfer_log.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("bp_order_%0d", i), xfer_log[i], bp_exp[i]);

        // saturation on ch1
        out_ready = 1'b0;
        pulse_ch(4'b0010, 5);
        check("sat_overflow_set", overflow, 4'b0010);
        check("sat_stalled_ch", out_ch, 1);
        xfer_log.delete();
        out_ready = 1'b1;
        wait_idle(20);
        n1 = 0;
        foreach (xfer_log[i]) if (xfer_log[i] == 1) n1++;
        check("sat_total_transfers", xfer_log.size(), 4);
        check("sat_ch1_transfers", n1, 4);
        ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
        check("sat_overflow_cleared", overflow, 0);

        // clear and new overflow in the same cycle: set wins
        out_ready = 1'b0;
        pulse_ch(4'b0010, 4);
        check("simul_pre_overflow", overflow, 0);
        evt_in[1] = 1'b1;
        tick(2);
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        check("simul_set_beats_clear", overflow, 4'b0010);
        evt_in[1] = 1'b0;
        tick(1);
        ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
        out_ready = 1'b1;
        wait_idle(20);
        check("simul_overflow_cleared", overflow, 0);

        // enable drop during an accepted transfer
        out_ready = 1'b0;
        pulse_ch(4'b1001, 1);
        tick(1);
        xfer_log.delete();
        out_ready = 1'b1;
        enable = 1'b0;
        tick(1);
        check("dis_valid_dropped", out_valid, 0);
        check("dis_busy_pending", busy, 1);
        evt_in[2] = 1'b1;
        tick(6);
        check("dis_no_grant", out_valid, 0);
        check("dis_one_transfer", xfer_log.size(), 1);
        enable = 1'b1;
        tick(2);
        evt_in[2] = 1'b0;
        wait_idle(20);
        check("en_count", xfer_log.size(), 3);
        if (xfer_log.size() == 3)
            for (int i = 0; i < 3; i++) check($sformatf("en_order_%0d", i), xfer_log[i], en_exp[i]);

        // mid-stream reset
        out_ready = 1'b0;
        pulse_ch(4'b0011, 2);
        check("mid_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ch", out_ch, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        tick(1);

        // randomized traffic
        for (int c = 0; c < NUM_CH; c++) hold[c] = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hold[c]++;
                if (hold[c] >= 2 && $urandom_range(0, 3) == 0) begin
                    evt_in[c] = ~evt_in[c];
                    hold[c]   = 0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            enable    = ($urandom_range(0, 15) != 0);
            ovf_clear = ($urandom_range(0, 31) == 0);
            tick(1);
        end
        evt_in = '0; enable = 1'b1; out_ready = 1'b1; ovf_clear = 1'b0;
        tick(2);
        wait_idle(100);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
